// File: rtl/ebus_arb_if.sv
// Bundle between the EBUS arbiter (slave side) and its requesters (master side).
interface ebus_arb_if #(
    parameter int N_REQ = 4
);
    logic [0:N_REQ-1]    req;
    logic [0:36*N_REQ-1] reqData;
    logic                edpHalfL;
    logic                edpHalfR;
    logic                clrTimeout;
    logic [0:N_REQ-1]    grant;
    logic [0:35]         EBUS;
    logic                ebusBusy;
    logic                CTL_adToEBUS_L;
    logic                CTL_adToEBUS_R;
    logic                ebusTimeout;
    logic [0:2]          timeoutId;

    modport slave (
        input  req, reqData, edpHalfL, edpHalfR, clrTimeout,
        output grant, EBUS, ebusBusy, CTL_adToEBUS_L, CTL_adToEBUS_R, ebusTimeout, timeoutId
    );

    modport master (
        output req, reqData, edpHalfL, edpHalfR, clrTimeout,
        input  grant, EBUS, ebusBusy, CTL_adToEBUS_L, CTL_adToEBUS_R, ebusTimeout, timeoutId
    );
endinterface

// File: rtl/ebus_arb.sv
// Round-robin owner of the shared 36-bit EBUS with a dead TURN cycle between owners and a hold limit.
// Grant is registered one edge after request; EBUS mux is combinational off the grant; owners past HOLD_MAX are forced off.
module ebus_arb #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic      eboxClk,
    input  logic      resetN,
    ebus_arb_if.slave bus
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t           state_q, state_d;
    logic [0:N_REQ-1] grant_q, grant_d;
    logic [0:N_REQ-1] blocked_q, blocked_d;
    logic [0:N_REQ-1] elig;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    cand, win_idx;
    logic             win_vld;
    logic [7:0]       hold_q, hold_d;
    logic             tmo_q, tmo_d;
    logic [2:0]       tmo_id_q, tmo_id_d;
    logic [0:35]      ebus_mux;

    // Search starts one past the last owner, so a just-released owner goes to the back of the line.
    always_comb begin
        elig    = bus.req & ~blocked_q;
        win_vld = 1'b0;
        win_idx = last_q;
        cand    = last_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + IW'(1);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q & ~bus.clrTimeout;
        tmo_id_d  = tmo_id_q;
        blocked_d = blocked_q & bus.req;
        unique case (state_q)
            IDLE, TURN: begin
                grant_d = '0;
                state_d = IDLE;
                if (win_vld) begin
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                    hold_d           = '0;
                    state_d          = OWN;
                end
            end
            OWN: begin
                hold_d = hold_q + 8'd1;
                if (!bus.req[last_q]) begin
                    grant_d = '0;
                    state_d = TURN;
                end else if (hold_q == 8'(HOLD_MAX - 1)) begin
                    grant_d           = '0;
                    state_d           = TURN;
                    tmo_d             = 1'b1;
                    tmo_id_d          = 3'(last_q);
                    blocked_d[last_q] = 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge eboxClk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            blocked_q <= '0;
            last_q    <= IW'(N_REQ - 1);
            hold_q    <= '0;
            tmo_q     <= 1'b0;
            tmo_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            blocked_q <= blocked_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            tmo_id_q  <= tmo_id_d;
        end
    end

    // Slot 0 is the EDP, which may drive only one half of the bus.
    always_comb begin
        ebus_mux = '0;
        for (int i = 1; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                ebus_mux = bus.reqData[36*i +: 36];
            end
        end
        if (grant_q[0]) begin
            ebus_mux = {bus.reqData[0:17]  & {18{bus.edpHalfL}},
                        bus.reqData[18:35] & {18{bus.edpHalfR}}};
        end
    end

    assign bus.grant          = grant_q;
    assign bus.EBUS           = ebus_mux;
    assign bus.ebusBusy       = |grant_q;
    assign bus.CTL_adToEBUS_L = grant_q[0] & bus.edpHalfL;
    assign bus.CTL_adToEBUS_R = grant_q[0] & bus.edpHalfR;
    assign bus.ebusTimeout    = tmo_q;
    assign bus.timeoutId      = tmo_id_q;
endmodule

// File: tb/tb_ebus_arb.sv
// Bench for ebus_arb: burst scoreboard (owner, length, gap) plus direct flag and data checks.
module tb_ebus_arb;
    localparam int N  = 4;
    localparam int HM = 16;

    logic eboxClk = 1'b0;
    logic resetN  = 1'b1;

    ebus_arb_if #(.N_REQ(N)) bus();

    ebus_arb #(.N_REQ(N), .HOLD_MAX(HM)) dut (
        .eboxClk (eboxClk),
        .resetN  (resetN),
        .bus     (bus)
    );

    always #5 eboxClk = ~eboxClk;

    typedef struct {
        int id;
        int len;
        int gap;
    } burst_t;

    burst_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cur_id    = -1;
    int     cur_len   = 0;
    int     start_gap = 0;
    int     idle_cnt  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:35] slot_val(input int i);
        return 36'h0A5000000 + 36'(i) * 36'h111;
    endfunction

    function automatic logic [0:N-1] onehot(input int i);
        logic [0:N-1] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:35] model_ebus(input int gid);
        logic [0:35] d;
        d = '0;
        if (gid >= 0) d = bus.reqData[36*gid +: 36];
        if (gid == 0) begin
            if (!bus.edpHalfL) d[0:17]  = '0;
            if (!bus.edpHalfR) d[18:35] = '0;
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge eboxClk);
        #1;
    endtask

    task automatic push_burst(input int id, input int len, input int gap);
        burst_t b;
        b.id  = id;
        b.len = len;
        b.gap = gap;
        exp_q.push_back(b);
    endtask

    task automatic end_burst();
        burst_t e;
        check_eq("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("burst_id", 64'(cur_id), 64'(e.id));
            check_eq("burst_len", 64'(cur_len), 64'(e.len));
            if (e.gap >= 0) check_eq("burst_gap", 64'(start_gap), 64'(e.gap));
        end
    endtask

    always @(negedge eboxClk) begin
        int gid;
        gid = -1;
        for (int i = 0; i < N; i++) if (bus.grant[i]) gid = i;
        check_eq("onehot", 64'($countones(bus.grant) <= 1), 64'd1);
        check_eq("busy", 64'(bus.ebusBusy), 64'(bus.grant != '0));
        check_eq("ebus", 64'(bus.EBUS), 64'(model_ebus(gid)));
        check_eq("ctl_l", 64'(bus.CTL_adToEBUS_L), 64'(bus.grant[0] & bus.edpHalfL));
        check_eq("ctl_r", 64'(bus.CTL_adToEBUS_R), 64'(bus.grant[0] & bus.edpHalfR));
        if (gid != cur_id) begin
            if (cur_id >= 0) begin
                end_burst();
                idle_cnt = 0;
            end
            if (gid >= 0) begin
                start_gap = idle_cnt;
                cur_len   = 0;
            end
            cur_id = gid;
        end
        if (gid >= 0) cur_len++;
        else idle_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[N];
        int served;
        int cyc;

        bus.req        = '0;
        bus.edpHalfL   = 1'b1;
        bus.edpHalfR   = 1'b1;
        bus.clrTimeout = 1'b0;
        for (int i = 0; i < N; i++) bus.reqData[36*i +: 36] = slot_val(i);

        #1 resetN = 1'b0;
        @(negedge eboxClk);
        check_eq("rst_grant", 64'(bus.grant), 64'd0);
        check_eq("rst_ebus", 64'(bus.EBUS), 64'd0);
        check_eq("rst_busy", 64'(bus.ebusBusy), 64'd0);
        check_eq("rst_ctl", 64'({bus.CTL_adToEBUS_L, bus.CTL_adToEBUS_R}), 64'd0);
        check_eq("rst_tmo", 64'(bus.ebusTimeout), 64'd0);
        check_eq("rst_tmo_id", 64'(bus.timeoutId), 64'd0);
        tick();
        resetN = 1'b1;
        tick();

        // Round robin: everyone requests, each owner leaves after 3 grant cycles and re-requests.
        push_burst(0, 3, -1);
        push_burst(1, 3, 1);
        push_burst(2, 3, 1);
        push_burst(3, 3, 1);
        push_burst(0, 3, 1);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        served  = 0;
        cyc     = 0;
        bus.req = '1;
        while (served < 5 && cyc < 200) begin
            tick();
            cyc++;
            for (int i = 0; i < N; i++) if (!bus.req[i]) bus.req[i] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (bus.grant[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 3) begin
                        bus.req[i] = 1'b0;
                        cnt[i]     = 0;
                        served++;
                    end
                end
            end
        end
        check_eq("rr_served", 64'(served), 64'd5);
        bus.req = '0;
        repeat (3) tick();

        // EDP drives only its left half.
        bus.reqData[0:35] = 36'h123456789;
        bus.edpHalfL      = 1'b1;
        bus.edpHalfR      = 1'b0;
        push_burst(0, 2, -1);
        bus.req[0] = 1'b1;
        tick();
        check_eq("edp_grant", 64'(bus.grant), 64'(onehot(0)));
        check_eq("edp_ebus", 64'(bus.EBUS), 64'(36'h123440000));
        check_eq("edp_ctl_l", 64'(bus.CTL_adToEBUS_L), 64'd1);
        check_eq("edp_ctl_r", 64'(bus.CTL_adToEBUS_R), 64'd0);
        tick();
        bus.req[0] = 1'b0;
        repeat (2) tick();
        bus.edpHalfR = 1'b1;
        bus.reqData[0:35] = slot_val(0);
        tick();

        // Forced release of requester 2, then re-request after one low cycle.
        push_burst(2, HM, -1);
        push_burst(2, HM, -1);
        bus.req[2] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == HM) begin
                check_eq("tmo_pre", 64'(bus.ebusTimeout), 64'd0);
                check_eq("tmo_pre_grant", 64'(bus.grant), 64'(onehot(2)));
            end
            if (c == HM + 1) begin
                check_eq("tmo_set", 64'(bus.ebusTimeout), 64'd1);
                check_eq("tmo_id", 64'(bus.timeoutId), 64'd2);
                check_eq("tmo_drop", 64'(bus.grant), 64'd0);
            end
            if (c == 20) check_eq("tmo_blocked", 64'(bus.grant), 64'd0);
        end
        bus.req[2]     = 1'b0;
        bus.clrTimeout = 1'b1;
        tick();
        check_eq("clr_alone1", 64'(bus.ebusTimeout), 64'd0);
        bus.clrTimeout = 1'b0;
        bus.req[2]     = 1'b1;
        for (int c = 1; c <= HM + 1; c++) begin
            tick();
            if (c == HM) bus.clrTimeout = 1'b1;
            if (c == HM + 1) begin
                check_eq("tmo_set_wins", 64'(bus.ebusTimeout), 64'd1);
                check_eq("tmo_id2", 64'(bus.timeoutId), 64'd2);
                bus.clrTimeout = 1'b0;
            end
        end
        bus.req[2] = 1'b0;
        repeat (2) tick();
        bus.clrTimeout = 1'b1;
        tick();
        check_eq("clr_alone2", 64'(bus.ebusTimeout), 64'd0);
        check_eq("tmo_id_hold", 64'(bus.timeoutId), 64'd2);
        bus.clrTimeout = 1'b0;
        tick();

        // Asynchronous reset in the middle of requester 1's ownership.
        push_burst(1, 2, -1);
        push_burst(1, 3, -1);
        bus.req[1] = 1'b1;
        repeat (3) tick();
        #1 resetN = 1'b0;
        #1;
        check_eq("arst_grant", 64'(bus.grant), 64'd0);
        check_eq("arst_ebus", 64'(bus.EBUS), 64'd0);
        check_eq("arst_busy", 64'(bus.ebusBusy), 64'd0);
        @(negedge eboxClk);
        #1 resetN = 1'b1;
        tick();
        check_eq("arst_regrant", 64'(bus.grant), 64'(onehot(1)));
        repeat (2) tick();
        bus.req[1] = 1'b0;
        repeat (3) tick();

        // Lone request on an idle bus.
        push_burst(3, 3, -1);
        bus.req[3] = 1'b1;
        tick();
        check_eq("lone_grant", 64'(bus.grant), 64'(onehot(3)));
        check_eq("lone_ebus", 64'(bus.EBUS), 64'(slot_val(3)));
        repeat (2) tick();
        bus.req[3] = 1'b0;
        repeat (4) tick();

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
